// File: rtl/feature_eltwise.sv
// Element-wise add/sub/max combiner of two joined ready/valid feature streams,
// with arithmetic shift and saturation over a 2-stage stallable pipeline.
// Optional ReLU stage enabled by defining FEATURE_ELTWISE_RELU_EN (adds relu_en port).
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 16
`endif

module feature_eltwise #(
  parameter int unsigned FEATURE_WIDTH = `FEATURE_WIDTH,
  parameter int unsigned LANES         = 8,
  parameter int unsigned LEN_WIDTH     = 16
) (
  input  logic                           system_clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [LEN_WIDTH-1:0]           cfg_len,
  input  logic [1:0]                     cfg_mode,
  input  logic [1:0]                     cfg_shift,
`ifdef FEATURE_ELTWISE_RELU_EN
  input  logic                           relu_en,
`endif
  input  logic [FEATURE_WIDTH*LANES-1:0] x1_data,
  input  logic                           x1_valid,
  output logic                           x1_ready,
  input  logic [FEATURE_WIDTH*LANES-1:0] x2_data,
  input  logic                           x2_valid,
  output logic                           x2_ready,
  output logic [FEATURE_WIDTH*LANES-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned FW = FEATURE_WIDTH;
  localparam int unsigned EW = FEATURE_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [LEN_WIDTH-1:0]   remaining;
  logic [1:0]             mode_q;
  logic [1:0]             shift_q;
  logic                   relu_q;
  logic                   zero_done_q;
  logic                   adv, accept, fire, drain_done;
  logic                   s1_valid;
  logic [EW*LANES-1:0]    s1_data, s1_next;
  logic [FW*LANES-1:0]    s2_next;

  // Operands widened by one bit so add/sub never wrap before saturation.
  function automatic logic signed [EW-1:0] lane_op(input logic [FW-1:0] p,
                                                   input logic [FW-1:0] q,
                                                   input logic [1:0]    mode,
                                                   input logic [1:0]    sh);
    logic signed [EW-1:0] a, b, r;
    a = {p[FW-1], p};
    b = {q[FW-1], q};
    case (mode)
      2'd1:    r = a - b;
      2'd2:    r = (a > b) ? a : b;
      default: r = a + b;
    endcase
    return r >>> sh;
  endfunction

  function automatic logic [FW-1:0] lane_sat(input logic [EW-1:0] v, input logic relu);
    logic [FW-1:0] r;
    if (v[EW-1] != v[EW-2])
      r = v[EW-1] ? {1'b1, {(FW-1){1'b0}}} : {1'b0, {(FW-1){1'b1}}};
    else
      r = v[FW-1:0];
    if (relu && r[FW-1])
      r = '0;
    return r;
  endfunction

  always_ff @(posedge system_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && cfg_len != '0) state_nxt = RUN;
      RUN:     if (fire && remaining == LEN_WIDTH'(1)) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    adv        = !out_valid || out_ready;
    accept     = (state == RUN) && (remaining != '0) && adv;
    x1_ready   = accept && x2_valid;
    x2_ready   = accept && x1_valid;
    fire       = accept && x1_valid && x2_valid;
    // Stage 1 is empty and stage 2 is empty or leaving: last beat gone.
    drain_done = (state == DRAIN) && !s1_valid && adv;
    busy       = (state != IDLE);
    done       = drain_done || zero_done_q;
  end

  always_ff @(posedge system_clk) begin
    if (rst) begin
      remaining   <= '0;
      mode_q      <= '0;
      shift_q     <= '0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= (state == IDLE) && start && (cfg_len == '0);
      if (state == IDLE && start) begin
        remaining <= cfg_len;
        mode_q    <= cfg_mode;
        shift_q   <= cfg_shift;
      end else if (fire) begin
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

`ifdef FEATURE_ELTWISE_RELU_EN
  always_ff @(posedge system_clk) begin
    if (rst)                         relu_q <= 1'b0;
    else if (state == IDLE && start) relu_q <= relu_en;
  end
`else
  assign relu_q = 1'b0;
`endif

  always_comb begin
    s1_next = '0;
    s2_next = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      s1_next[EW*i +: EW] = lane_op(x1_data[FW*i +: FW], x2_data[FW*i +: FW], mode_q, shift_q);
      s2_next[FW*i +: FW] = lane_sat(s1_data[EW*i +: EW], relu_q);
    end
  end

  always_ff @(posedge system_clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      s1_valid  <= fire;
      if (fire) s1_data <= s1_next;
      out_valid <= s1_valid;
      if (s1_valid) out_data <= s2_next;
    end
  end

endmodule
